// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
//   Shared definitions for the single-port RAM controller:
//   - read-during-write mode encodings (RDW_OLD / RDW_NEW / RDW_NOCHG)
//   - clear-sequencer state enum {CLEAR, READY}
//   - addr_width(): address width for a given depth, never below 1 bit
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int RDW_OLD   = 0;  // write echoes the pre-write word
  localparam int RDW_NEW   = 1;  // write echoes the post-merge word
  localparam int RDW_NOCHG = 2;  // write produces no read response

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ---------------------------------------------------------------------------
// ram_clear_seq
//   Post-reset / on-demand clear sweep for the RAM array. After reset (or an
//   accepted clear pulse) it walks word addresses 0..DEPTH-1, one per cycle,
//   and requests a write of the init value at each. Requests from the user
//   port are only accepted while the sweep is idle (ready=1).
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clear       in   restart the sweep (honoured only while ready=1)
//   ready       out  1 = array available to user requests this cycle
//   init_done   out  sticky 1 after the first completed sweep
//   sweep_we    out  array write strobe for the sweep (has priority)
//   sweep_addr  out  word address being initialised
// ---------------------------------------------------------------------------
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  output logic              init_done,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              init_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    init_done_nxt = init_done;
    ready         = 1'b0;
    sweep_we      = 1'b0;
    sweep_addr    = cnt;

    case (state)
      CLEAR: begin
        sweep_we = 1'b1;
        if (cnt == LAST_ADDR) begin
          // Last word written this cycle: enter READY on the next edge,
          // and flag completion at the same moment.
          state_nxt     = READY;
          cnt_nxt       = '0;
          init_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      READY: begin
        ready = 1'b1;
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ram_1port_ctrl.sv
// ---------------------------------------------------------------------------
// ram_1port_ctrl
//   Single-port synchronous RAM with request/valid handshake, per-byte write
//   enables, selectable read-during-write behaviour and a hardware clear sweep
//   after reset. The array itself is not reset; its contents are defined once
//   the sweep completes (o_Init_Done).
//
// Configuration macro
//   RAM_OUT_REG_EN  defined: extra output register, read latency 2
//                   undefined: read latency 1
//
// Ports
//   i_Clk        in   clock, rising edge
//   i_Rst_L      in   asynchronous active-low reset
//   i_Clear      in   restart clear sweep (honoured only while o_Ready=1)
//   i_Req        in   request strobe; accepted when i_Req & o_Ready
//   i_WE         in   1 = write, 0 = read
//   i_Addr       in   word address (ADDR_W bits)
//   i_BE         in   byte enables, lane k covers bits [k*BYTE_W +: BYTE_W]
//   i_Wr_Data    in   write data
//   o_Ready      out  requests accepted this cycle
//   o_Init_Done  out  sticky, set after first sweep completes
//   o_Rd_Valid   out  one-cycle pulse qualifying o_Rd_Data
//   o_Rd_Data    out  read data, holds when o_Rd_Valid=0
// ---------------------------------------------------------------------------
module ram_1port_ctrl
  import ram_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 256,
  parameter int               BYTE_W   = 8,
  parameter int               RDW_MODE = RDW_OLD,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              NB       = WIDTH / BYTE_W,
  localparam int              ADDR_W   = addr_width(DEPTH)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Clear,
  input  logic              i_Req,
  input  logic              i_WE,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [NB-1:0]     i_BE,
  input  logic [WIDTH-1:0]  i_Wr_Data,
  output logic              o_Ready,
  output logic              o_Init_Done,
  output logic              o_Rd_Valid,
  output logic [WIDTH-1:0]  o_Rd_Data
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic              ready;
  logic              init_done;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic              rd_fire;
  logic [WIDTH-1:0]  old_word;
  logic [WIDTH-1:0]  merged_word;
  logic [WIDTH-1:0]  rd_word;

  ram_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (i_Clk),
    .rst_n      (i_Rst_L),
    .clear      (i_Clear),
    .ready      (ready),
    .init_done  (init_done),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  assign o_Ready     = ready;
  assign o_Init_Done = init_done;

  assign accept   = i_Req & ready;
  // Addresses beyond DEPTH are accepted but never touch the array.
  assign in_range = ({1'b0, i_Addr} < DEPTH_EXT);
  assign wr_en    = accept & i_WE & in_range;
  // In no-change mode a write produces no response at all.
  assign rd_fire  = accept & (~i_WE | (RDW_MODE != RDW_NOCHG));

  always_comb begin
    old_word = '0;
    if (in_range) begin
      old_word = mem[i_Addr];
    end
  end

  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < NB; k++) begin
      if (i_BE[k]) begin
        merged_word[k*BYTE_W +: BYTE_W] = i_Wr_Data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Out-of-range requests must echo zero, so the merged word is only
  // selected when the address actually hits the array.
  always_comb begin
    rd_word = old_word;
    if (i_WE && (RDW_MODE == RDW_NEW) && in_range) begin
      rd_word = merged_word;
    end
  end

  // Array write port: the clear sweep owns the port while it runs.
  always_ff @(posedge i_Clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= INIT_VAL;
    end else if (wr_en) begin
      mem[i_Addr] <= merged_word;
    end
  end

  // ---- stage p0: registered read response ----
  logic             vld_p0;
  logic [WIDTH-1:0] rd_data_p0;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vld_p0     <= 1'b0;
      rd_data_p0 <= '0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) begin
        rd_data_p0 <= rd_word;
      end
    end
  end

`ifdef RAM_OUT_REG_EN
  // ---- stage p1: optional output register ----
  logic             vld_p1;
  logic [WIDTH-1:0] rd_data_p1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1     <= vld_p0;
      rd_data_p1 <= rd_data_p0;
    end
  end

  assign o_Rd_Valid = vld_p1;
  assign o_Rd_Data  = rd_data_p1;
`else
  assign o_Rd_Valid = vld_p0;
  assign o_Rd_Data  = rd_data_p0;
`endif

endmodule

// File: tb/tb_ram_1port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_1port_ctrl
//   Three instances share one stimulus bus:
//     dut0: DEPTH=256, RDW old-data
//     dut1: DEPTH=200, RDW new-data
//     dut2: DEPTH=256, RDW no-change
//   All use WIDTH=16, BYTE_W=8, INIT_VAL=16'hA5A5.
// ---------------------------------------------------------------------------
module tb_ram_1port_ctrl;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [15:0] IV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [1:0]  be;
  logic [15:0] wdata;

  logic        rdy   [3];
  logic        idone [3];
  logic        rvld  [3];
  logic [15:0] rdat  [3];

  int n_checks = 0;
  int n_pass   = 0;
  logic got_echo;

  always #5 clk = ~clk;

  ram_1port_ctrl #(.WIDTH(16), .DEPTH(256), .BYTE_W(8), .RDW_MODE(0), .INIT_VAL(IV)) u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Clear(clear), .i_Req(req), .i_WE(we), .i_Addr(addr),
    .i_BE(be), .i_Wr_Data(wdata), .o_Ready(rdy[0]), .o_Init_Done(idone[0]),
    .o_Rd_Valid(rvld[0]), .o_Rd_Data(rdat[0]));

  ram_1port_ctrl #(.WIDTH(16), .DEPTH(200), .BYTE_W(8), .RDW_MODE(1), .INIT_VAL(IV)) u_dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Clear(clear), .i_Req(req), .i_WE(we), .i_Addr(addr),
    .i_BE(be), .i_Wr_Data(wdata), .o_Ready(rdy[1]), .o_Init_Done(idone[1]),
    .o_Rd_Valid(rvld[1]), .o_Rd_Data(rdat[1]));

  ram_1port_ctrl #(.WIDTH(16), .DEPTH(256), .BYTE_W(8), .RDW_MODE(2), .INIT_VAL(IV)) u_dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Clear(clear), .i_Req(req), .i_WE(we), .i_Addr(addr),
    .i_BE(be), .i_Wr_Data(wdata), .o_Ready(rdy[2]), .o_Init_Done(idone[2]),
    .o_Rd_Valid(rvld[2]), .o_Rd_Data(rdat[2]));

  typedef struct {
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [2:0]  vld;   // bit k = expected o_Rd_Valid of dut k
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic w, logic [7:0] a, logic [1:0] b, logic [15:0] wd,
                              logic [2:0] v, logic [15:0] e0, logic [15:0] e1, logic [15:0] e2);
    vec_t t;
    t.req = r; t.we = w; t.addr = a; t.be = b; t.wdata = wd;
    t.vld = v; t.d0 = e0; t.d1 = e1; t.d2 = e2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle();
    clear = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic drive(input vec_t v);
    req = v.req; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    logic [15:0] ed;
    for (int k = 0; k < 3; k++) begin
      ed = (k == 0) ? v.d0 : ((k == 1) ? v.d1 : v.d2);
      chk($sformatf("v%0d_vld%0d", idx, k), 32'(rvld[k]), 32'(v.vld[k]));
      chk($sformatf("v%0d_data%0d", idx, k), 32'(rdat[k]), 32'(ed));
    end
  endtask

  // Vectors issue back-to-back; vector i's response is checked LAT cycles later.
  task automatic run_vectors();
    int n;
    n = vq.size();
    for (int i = 0; i < n + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) check_vec(vq[i-LAT], i - LAT);
      if (i < n) drive(vq[i]);
      else idle();
    end
    vq.delete();
  endtask

  // Counts edges (starting at 1) until each instance asserts o_Ready.
  task automatic count_ready(input int exp0, input int exp1, input logic idone_exp);
    int   c0;
    int   c1;
    logic idone_ok;
    c0 = -1; c1 = -1; idone_ok = 1'b1;
    for (int c = 1; c <= 400 && (c0 < 0 || c1 < 0); c++) begin
      @(posedge clk); #1;
      if (rvld[1] && rdat[1] == 16'h4242) got_echo = 1'b1;
      if (c0 < 0 && rdy[0]) c0 = c;
      if (c1 < 0 && rdy[1]) c1 = c;
      if (c0 < 0 && idone[0] !== idone_exp) idone_ok = 1'b0;
      if (c1 < 0 && idone[1] !== idone_exp) idone_ok = 1'b0;
      if (c0 >= 0 && idone[0] !== 1'b1) idone_ok = 1'b0;
    end
    chk("ready_cycles_d256", 32'(c0), 32'(exp0));
    chk("ready_cycles_d200", 32'(c1), 32'(exp1));
    chk("init_done_track", 32'(idone_ok), 32'd1);
  endtask

  task automatic add_full_readback();
    for (int a = 0; a < 256; a++)
      vq.push_back(mk(1, 0, 8'(a), 2'b00, 16'h0, 3'b111, IV, (a < 200) ? IV : 16'h0, IV));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] old_w;
    logic [15:0] hold2;

    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_init_done%0d", k), 32'(idone[k]), 32'd0);
      chk($sformatf("rst_rd_valid%0d", k), 32'(rvld[k]), 32'd0);
      chk($sformatf("rst_rd_data%0d", k), 32'(rdat[k]), 32'd0);
    end
    rst_n = 1'b1;
    count_ready(256, 200, 1'b0);

    // Every word holds INIT_VAL; out-of-range on dut1 reads zero.
    add_full_readback();
    run_vectors();

    // Directed table: merges, RDW modes, BE=0, out-of-range, aliasing.
    vq.push_back(mk(1, 0, 8'd3,   2'b00, 16'h0000, 3'b111, IV,       IV,       IV));
    vq.push_back(mk(1, 1, 8'd5,   2'b11, 16'h1234, 3'b011, IV,       16'h1234, IV));
    vq.push_back(mk(1, 1, 8'd5,   2'b10, 16'hFF00, 3'b011, 16'h1234, 16'hFF34, IV));
    vq.push_back(mk(1, 0, 8'd5,   2'b00, 16'h0000, 3'b111, 16'hFF34, 16'hFF34, 16'hFF34));
    vq.push_back(mk(1, 1, 8'd9,   2'b11, 16'h1111, 3'b011, IV,       16'h1111, 16'hFF34));
    vq.push_back(mk(1, 1, 8'd9,   2'b11, 16'h2222, 3'b011, 16'h1111, 16'h2222, 16'hFF34));
    vq.push_back(mk(1, 0, 8'd9,   2'b00, 16'h0000, 3'b111, 16'h2222, 16'h2222, 16'h2222));
    vq.push_back(mk(1, 1, 8'd9,   2'b00, 16'hBEEF, 3'b011, 16'h2222, 16'h2222, 16'h2222));
    vq.push_back(mk(1, 0, 8'd9,   2'b00, 16'h0000, 3'b111, 16'h2222, 16'h2222, 16'h2222));
    vq.push_back(mk(1, 1, 8'd9,   2'b01, 16'h00CD, 3'b011, 16'h2222, 16'h22CD, 16'h2222));
    vq.push_back(mk(1, 0, 8'd9,   2'b00, 16'h0000, 3'b111, 16'h22CD, 16'h22CD, 16'h22CD));
    vq.push_back(mk(1, 1, 8'd220, 2'b11, 16'h7777, 3'b011, IV,       16'h0000, 16'h22CD));
    vq.push_back(mk(1, 0, 8'd220, 2'b00, 16'h0000, 3'b111, 16'h7777, 16'h0000, 16'h7777));
    vq.push_back(mk(0, 0, 8'd5,   2'b00, 16'h0000, 3'b000, 16'h7777, 16'h0000, 16'h7777));
    vq.push_back(mk(1, 0, 8'd255, 2'b00, 16'h0000, 3'b111, IV,       16'h0000, IV));
    vq.push_back(mk(1, 0, 8'd199, 2'b00, 16'h0000, 3'b111, IV,       IV,       IV));
    vq.push_back(mk(1, 0, 8'd20,  2'b00, 16'h0000, 3'b111, IV,       IV,       IV));
    vq.push_back(mk(1, 0, 8'd92,  2'b00, 16'h0000, 3'b111, IV,       IV,       IV));
    run_vectors();

    // Write/read-next-cycle pairs, then a 16-deep read stream in order.
    for (int i = 0; i < 16; i++) begin
      old_w = (i == 5) ? 16'hFF34 : ((i == 9) ? 16'h22CD : IV);
      hold2 = (i == 0) ? IV : 16'(16'h1000 + i - 1);
      vq.push_back(mk(1, 1, 8'(i), 2'b11, 16'(16'h1000 + i), 3'b011, old_w, 16'(16'h1000 + i), hold2));
      vq.push_back(mk(1, 0, 8'(i), 2'b00, 16'h0, 3'b111,
                      16'(16'h1000 + i), 16'(16'h1000 + i), 16'(16'h1000 + i)));
    end
    for (int i = 0; i < 16; i++)
      vq.push_back(mk(1, 0, 8'(i), 2'b00, 16'h0, 3'b111,
                      16'(16'h1000 + i), 16'(16'h1000 + i), 16'(16'h1000 + i)));
    run_vectors();

    // Clear pulse with a concurrent write that must still complete.
    got_echo = 1'b0;
    @(negedge clk);
    clear = 1'b1; req = 1'b1; we = 1'b1; addr = 8'd7; be = 2'b11; wdata = 16'h4242;
    @(posedge clk); #1;
    idle();
    if (rvld[1] && rdat[1] == 16'h4242) got_echo = 1'b1;
    chk("clear_ready_low", 32'(rdy[0]), 32'd0);
    count_ready(256, 200, 1'b1);
    chk("clear_req_echo", 32'(got_echo), 32'd1);
    add_full_readback();
    run_vectors();

    // Async reset during an in-flight read drops the response.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 8'd3;
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midreq_rd_valid%0d", k), 32'(rvld[k]), 32'd0);
      chk($sformatf("midreq_rd_data%0d", k), 32'(rdat[k]), 32'd0);
      chk($sformatf("midreq_init_done%0d", k), 32'(idone[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-sweep: the sweep must restart from address 0.
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(256, 200, 1'b0);
    vq.push_back(mk(1, 0, 8'd5,   2'b00, 16'h0, 3'b111, IV, IV,       IV));
    vq.push_back(mk(1, 0, 8'd220, 2'b00, 16'h0, 3'b111, IV, 16'h0000, IV));
    run_vectors();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
